fft_seq: RTL and testbench
==========================

Name: fft_seq

Overview:
- Control sequencer for the in-place radix-2 DIT FFT coprocessor attached to the openMSP430 system.
- On a start pulse it walks all LOG2N stages and N/2 butterflies per stage, in that order.
- For each butterfly it drives the single-port sample RAM (two reads, two writes) and the pipelined butterfly unit: operand capture, launch, twiddle index and write-back select.
- Input samples are already in bit-reversed order in the sample RAM when start is asserted.

Parameters:
- LOG2N, 4, log2 of FFT length (N = 16); sets the address width and number of stages.
- BFLY_LAT, 2, butterfly unit latency in cycles from bfly_go to result valid; 0 is legal.

Ports:
- mclk  input  1  system clock
- reset_n  input  1  synchronous reset, active-low
- start  input  1  run request; sampled only in IDLE
- scale_mask  input  LOG2N  per-stage scale enable; bit s applies to stage s
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle completion pulse
- stage  output  LOG2N  current stage index, 0..LOG2N-1
- ram_cen  output  1  sample RAM chip enable, low active
- ram_wen  output  2  sample RAM write enable, low active; both bits always equal
- ram_addr  output  LOG2N  sample RAM word address
- bfly_a_ld  output  1  latch ram_dout into operand A
- bfly_b_ld  output  1  latch ram_dout into operand B
- bfly_go  output  1  launch butterfly
- bfly_tw_idx  output  LOG2N-1  twiddle index
- bfly_scale  output  1  shift result right by 1 for this butterfly
- bfly_wr_sel  output  1  write-back data select: 0 = A', 1 = B'

Behaviour:
- Reset (synchronous, reset_n=0 at a mclk edge):
  - state=IDLE.
  - busy=0, done=0, stage=0, ram_cen=1, ram_wen=2'b11, ram_addr=0.
  - All bfly_* outputs 0.
  - Butterfly and wait counters cleared.
  - Applies mid-run: the run is abandoned with no further RAM accesses.
- RAM timing: synchronous read; data is valid the cycle after the cen=0 read cycle.
- Butterfly b (0..N/2-1) in stage s:
  - span = 1<<s
  - addr_a = ((b>>s)<<(s+1)) | (b & (span-1))
  - addr_b = addr_a + span
  - bfly_tw_idx = (b & (span-1)) << (LOG2N-1-s)
- Per-butterfly FSM (cen=0 only in the read/write states below):
  - RD_A: cen=0, wen=11, addr=addr_a.
  - RD_B: cen=0, wen=11, addr=addr_b, bfly_a_ld=1.
  - CAP: bfly_b_ld=1, bfly_go=1. bfly_tw_idx and bfly_scale are valid in this cycle.
  - WAIT: BFLY_LAT cycles; skipped when BFLY_LAT=0.
  - WR_A: cen=0, wen=00, addr=addr_a, bfly_wr_sel=0.
  - WR_B: cen=0, wen=00, addr=addr_b, bfly_wr_sel=1.
  - After WR_B:
    - If more butterflies remain in the stage, increment b and go to RD_A.
    - If b was the last of the stage, set b=0, increment stage and go to RD_A.
    - If it was the last butterfly of the last stage, go to DONE.
- Cycle count: 5+BFLY_LAT cycles per butterfly; (N/2)·LOG2N·(5+BFLY_LAT) cycles in total (224 at defaults).
- Handshake:
  - start=1 in IDLE at edge k gives RD_A at k+1 (stage=0, b=0); busy is high from k+1.
  - DONE lasts one cycle with done=1 and busy=1, then IDLE.
  - start in any non-IDLE state is ignored: not queued, no effect.
  - start held high continuously causes a restart on the cycle after DONE returns to IDLE.
- scale_mask is latched when start is accepted; changes during a run have no effect.
- stage and counter wrap: none. The counters never exceed their terminal values; the DONE transition prevents overflow.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: FFT_SEQ_SCALE_EN.
- Defined: bfly_scale = latched scale_mask[stage] during CAP, 0 in all other states.
- Undefined: bfly_scale is constant 0 and scale_mask is ignored (port retained, no latch register synthesised).

Test Plan:
- Reset then start pulse (defaults): busy rises one cycle later; done pulses exactly 225 cycles after the start edge; busy falls the cycle after done.
- Trace the RAM address sequence of a full run:
  - stage 0, b=0: reads 0 then 1, twiddle 0
  - stage 1, b=5: addresses 9/11, twiddle 4
  - stage 2, b=3: addresses 3/7, twiddle 6
  - stage 3, b=7: addresses 7/15, twiddle 7
  - each butterfly: exactly 2 reads (wen=11) followed by 2 writes (wen=00)
- BFLY_LAT=0 build: 5 cycles per butterfly, done 161 cycles after start; BFLY_LAT=5 build: done 321 cycles after start.
- Start pulses during stage 2 → ignored, no sequence disturbance. start held high → second run begins the cycle after IDLE is re-entered.
- Assert reset_n=0 for one cycle during stage 1 WAIT → next cycle all outputs at reset values, ram_cen=1, and no write occurs.
- With FFT_SEQ_SCALE_EN defined and scale_mask=4'b1010 → bfly_scale=1 in CAP of stages 1 and 3 only. Without the macro, bfly_scale=0 throughout.

Source files
------------

// File: rtl/fft_seq_if.sv
// fft_seq_if: control/status and sample-RAM/butterfly-unit bundle of the
// FFT sequencer.
//   master : sequencer side (drives busy/done/stage, RAM and butterfly controls)
//   slave  : host / datapath side (drives start, scale_mask)
interface fft_seq_if #(
   parameter int LOG2N = 4
);
   logic             start;
   logic [LOG2N-1:0] scale_mask;
   logic             busy;
   logic             done;
   logic [LOG2N-1:0] stage;
   logic             ram_cen;
   logic [1:0]       ram_wen;
   logic [LOG2N-1:0] ram_addr;
   logic             bfly_a_ld;
   logic             bfly_b_ld;
   logic             bfly_go;
   logic [LOG2N-2:0] bfly_tw_idx;
   logic             bfly_scale;
   logic             bfly_wr_sel;

   modport master (
      input  start, scale_mask,
      output busy, done, stage, ram_cen, ram_wen, ram_addr,
             bfly_a_ld, bfly_b_ld, bfly_go, bfly_tw_idx, bfly_scale, bfly_wr_sel
   );

   modport slave (
      output start, scale_mask,
      input  busy, done, stage, ram_cen, ram_wen, ram_addr,
             bfly_a_ld, bfly_b_ld, bfly_go, bfly_tw_idx, bfly_scale, bfly_wr_sel
   );
endinterface

// File: rtl/fft_seq.sv
// fft_seq: control sequencer for the in-place radix-2 DIT FFT coprocessor.
// Walks LOG2N stages x N/2 butterflies; per butterfly: read A, read B,
// capture/launch, wait BFLY_LAT cycles, write A', write B'.
// Ports:
//   mclk     system clock
//   reset_n  synchronous reset, active low
//   bus      fft_seq_if.master: start/scale_mask in; busy, done, stage,
//            sample-RAM controls and butterfly-unit controls out
// Optional feature macro: FFT_SEQ_SCALE_EN (per-stage result scaling from the
// scale_mask latched at start; without it bfly_scale is tied low).
// All outputs are registered decodes of the current state, so every output
// trails the internal state by one cycle.
module fft_seq #(
   parameter int LOG2N    = 4,
   parameter int BFLY_LAT = 2
) (
   input  logic       mclk,
   input  logic       reset_n,
   fft_seq_if.master  bus
);

   typedef enum logic [2:0] {IDLE, RD_A, RD_B, CAP, WAIT, WR_A, WR_B, DONE} state_t;

   localparam logic [LOG2N-2:0] BFLY_LAST = '1;
   localparam logic [LOG2N-1:0] STG_LAST  = LOG2N'(LOG2N - 1);
   localparam logic [7:0]       LAT_LAST  = 8'(BFLY_LAT - 1);

   state_t           state;
   logic [LOG2N-2:0] bfly;
   logic [LOG2N-1:0] stg;
   logic [7:0]       wcnt;

   // butterfly address / twiddle for the current (stg, bfly)
   logic [LOG2N-1:0] span, bext, addr_a, addr_b;
   logic [LOG2N-2:0] tw;

   always_comb begin
      span   = LOG2N'(1) << stg;
      bext   = {1'b0, bfly};
      addr_a = ((bext >> stg) << (stg + LOG2N'(1))) | (bext & (span - LOG2N'(1)));
      addr_b = addr_a + span;
      tw     = (LOG2N-1)'((bext & (span - LOG2N'(1))) << (STG_LAST - stg));
   end

`ifdef FFT_SEQ_SCALE_EN
   logic [LOG2N-1:0] scl_q;
`else
   logic unused_scale;
   assign unused_scale = ^bus.scale_mask;
`endif

   always_ff @(posedge mclk) begin
      if (!reset_n) begin
         state           <= IDLE;
         bfly            <= '0;
         stg             <= '0;
         wcnt            <= '0;
`ifdef FFT_SEQ_SCALE_EN
         scl_q           <= '0;
`endif
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.stage       <= '0;
         bus.ram_cen     <= 1'b1;
         bus.ram_wen     <= 2'b11;
         bus.ram_addr    <= '0;
         bus.bfly_a_ld   <= 1'b0;
         bus.bfly_b_ld   <= 1'b0;
         bus.bfly_go     <= 1'b0;
         bus.bfly_tw_idx <= '0;
         bus.bfly_scale  <= 1'b0;
         bus.bfly_wr_sel <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state <= RD_A;
               bfly  <= '0;
               stg   <= '0;
`ifdef FFT_SEQ_SCALE_EN
               scl_q <= bus.scale_mask;
`endif
            end
            RD_A: state <= RD_B;
            RD_B: state <= CAP;
            CAP: begin
               wcnt <= '0;
               if (BFLY_LAT == 0) state <= WR_A;
               else               state <= WAIT;
            end
            WAIT: begin
               if (wcnt == LAT_LAST) state <= WR_A;
               else                  wcnt  <= wcnt + 8'd1;
            end
            WR_A: state <= WR_B;
            WR_B: begin
               if (bfly == BFLY_LAST) begin
                  bfly <= '0;
                  if (stg == STG_LAST) state <= DONE;
                  else begin
                     stg   <= stg + LOG2N'(1);
                     state <= RD_A;
                  end
               end else begin
                  bfly  <= bfly + (LOG2N-1)'(1);
                  state <= RD_A;
               end
            end
            DONE: begin
               state <= IDLE;
               stg   <= '0;
            end
            default: state <= IDLE;
         endcase

         // registered output decode of the current state
         bus.busy        <= (state != IDLE);
         bus.done        <= (state == DONE);
         bus.stage       <= stg;
         bus.ram_cen     <= !(state inside {RD_A, RD_B, WR_A, WR_B});
         bus.ram_wen     <= (state inside {WR_A, WR_B}) ? 2'b00 : 2'b11;
         bus.ram_addr    <= (state inside {RD_B, WR_B}) ? addr_b :
                            (state inside {RD_A, WR_A}) ? addr_a : '0;
         bus.bfly_a_ld   <= (state == RD_B);
         bus.bfly_b_ld   <= (state == CAP);
         bus.bfly_go     <= (state == CAP);
         bus.bfly_tw_idx <= (state == CAP) ? tw : '0;
         bus.bfly_wr_sel <= (state == WR_B);
`ifdef FFT_SEQ_SCALE_EN
         bus.bfly_scale  <= (state == CAP) && scl_q[stg];
`else
         bus.bfly_scale  <= 1'b0;
`endif
      end
   end

endmodule

// File: tb/tb_fft_seq.sv
// tb_fft_seq: self-checking bench for fft_seq. A reference model builds the
// expected RAM access list and per-butterfly capture values from the FFT
// address rules; the DUT trace is compared against it cycle by cycle.
module tb_fft_seq;
   localparam int LOG2N = 4;
   localparam int N     = 16;

   logic mclk    = 1'b0;
   logic reset_n = 1'b0;
   always #5 mclk = ~mclk;

   fft_seq_if #(.LOG2N(LOG2N)) sbus ();
   fft_seq_if #(.LOG2N(LOG2N)) bus0 ();
   fft_seq_if #(.LOG2N(LOG2N)) bus5 ();

   fft_seq #(.LOG2N(LOG2N), .BFLY_LAT(2)) dut    (.mclk(mclk), .reset_n(reset_n), .bus(sbus));
   fft_seq #(.LOG2N(LOG2N), .BFLY_LAT(0)) dut_l0 (.mclk(mclk), .reset_n(reset_n), .bus(bus0));
   fft_seq #(.LOG2N(LOG2N), .BFLY_LAT(5)) dut_l5 (.mclk(mclk), .reset_n(reset_n), .bus(bus5));

   int n_cmp = 0;
   int n_err = 0;

   // model: 0 = read A, 1 = read B, 2 = write A, 3 = write B
   int exp_addr[$];
   int exp_kind[$];
   int cap_stage[$];
   int cap_tw[$];
   int cap_sc[$];

   localparam logic [20:0] RST_V = {1'b0, 1'b0, 4'd0, 1'b1, 2'b11, 4'd0,
                                    1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

   function automatic logic [20:0] out_vec();
      return {sbus.busy, sbus.done, sbus.stage, sbus.ram_cen, sbus.ram_wen, sbus.ram_addr,
              sbus.bfly_a_ld, sbus.bfly_b_ld, sbus.bfly_go, sbus.bfly_tw_idx,
              sbus.bfly_scale, sbus.bfly_wr_sel};
   endfunction

   task automatic build_model(input logic [3:0] mask);
      int span, a, twv;
      exp_addr.delete(); exp_kind.delete();
      cap_stage.delete(); cap_tw.delete(); cap_sc.delete();
      for (int s = 0; s < LOG2N; s++) begin
         for (int b = 0; b < N / 2; b++) begin
            span = 2 ** s;
            a    = (b / span) * (2 * span) + (b % span);
            twv  = (b % span) * ((N / 2) / span);
            exp_addr.push_back(a);        exp_kind.push_back(0);
            exp_addr.push_back(a + span); exp_kind.push_back(1);
            exp_addr.push_back(a);        exp_kind.push_back(2);
            exp_addr.push_back(a + span); exp_kind.push_back(3);
            cap_stage.push_back(s);
            cap_tw.push_back(twv);
`ifdef FFT_SEQ_SCALE_EN
            cap_sc.push_back(int'(mask[s]));
`else
            cap_sc.push_back(0);
`endif
         end
      end
   endtask

   // One full run from a start pulse, checking the whole trace.
   task automatic run_check(input string name, input logic [3:0] mask, input bit noise);
      int ai, ci, done_c, done_n;
      bit busy_ok, side_ok;
      logic [3:0] ea;
      int k;
      logic [7:0] got_v, exp_v;
      logic [8:0] got_c, exp_c;
      build_model(mask);
      ai = 0; ci = 0; done_c = -1; done_n = 0; busy_ok = 1; side_ok = 1;
      sbus.scale_mask = mask;
      sbus.start = 1'b1;
      @(negedge mclk);
      sbus.start = 1'b0;
      for (int c = 1; c <= 226; c++) begin
         @(negedge mclk);
         if (c <= 225 && sbus.busy !== 1'b1) busy_ok = 0;
         if (c == 226 && sbus.busy !== 1'b0) busy_ok = 0;
         if (sbus.done === 1'b1) begin
            done_n++;
            if (done_c < 0) done_c = c;
         end
         if (sbus.ram_cen === 1'b0) begin
            n_cmp++;
            if (ai >= exp_addr.size()) begin
               n_err++;
               $display("FAIL %s extra_access: addr=%0d required no access", name, sbus.ram_addr);
            end else begin
               ea = 4'(exp_addr[ai]);
               k  = exp_kind[ai];
               got_v = {sbus.ram_addr, sbus.ram_wen, sbus.bfly_a_ld, sbus.bfly_wr_sel};
               exp_v = {ea, (k >= 2) ? 2'b00 : 2'b11, k == 1, k == 3};
               if (got_v !== exp_v) begin
                  n_err++;
                  $display("FAIL %s access[%0d] {addr,wen,a_ld,wr_sel}: got %h required %h",
                           name, ai, got_v, exp_v);
               end
            end
            ai++;
         end
         if (sbus.bfly_go === 1'b1) begin
            n_cmp++;
            if (ci >= cap_tw.size()) begin
               n_err++;
               $display("FAIL %s extra_cap: stage=%0d", name, sbus.stage);
            end else begin
               got_c = {sbus.bfly_b_ld, sbus.stage, sbus.bfly_tw_idx, sbus.bfly_scale};
               exp_c = {1'b1, 4'(cap_stage[ci]), 3'(cap_tw[ci]), 1'(cap_sc[ci])};
               if (got_c !== exp_c) begin
                  n_err++;
                  $display("FAIL %s cap[%0d] {b_ld,stage,tw,scale}: got %h required %h",
                           name, ci, got_c, exp_c);
               end
            end
            ci++;
         end else if (sbus.bfly_b_ld !== 1'b0 || sbus.bfly_scale !== 1'b0 ||
                      sbus.bfly_tw_idx !== 3'd0) begin
            side_ok = 0;
         end
         // ignored start pulses and mask changes while in stage 2
         if (noise) begin
            if (sbus.busy === 1'b1 && sbus.stage === 4'd2) begin
               sbus.start      = 1'($urandom % 2);
               sbus.scale_mask = 4'($urandom);
            end else sbus.start = 1'b0;
         end
      end
      sbus.start = 1'b0;
      n_cmp++;
      if (ai != 4 * LOG2N * (N / 2)) begin
         n_err++; $display("FAIL %s access_count: got %0d required %0d", name, ai, 4 * LOG2N * (N / 2));
      end
      n_cmp++;
      if (ci != LOG2N * (N / 2)) begin
         n_err++; $display("FAIL %s cap_count: got %0d required %0d", name, ci, LOG2N * (N / 2));
      end
      n_cmp++;
      if (done_c != 225 || done_n != 1) begin
         n_err++; $display("FAIL %s done_cycle: got %0d (pulses %0d) required 225 (1)", name, done_c, done_n);
      end
      n_cmp++;
      if (!busy_ok) begin
         n_err++; $display("FAIL %s busy_window: got wrong busy level required high 1..225 low at 226", name);
      end
      n_cmp++;
      if (!side_ok) begin
         n_err++; $display("FAIL %s outside_cap: got b_ld/scale/tw nonzero required zero", name);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge mclk);
      n_cmp++;
      if (out_vec() !== RST_V) begin
         n_err++; $display("FAIL reset_outputs: got %h required %h", out_vec(), RST_V);
      end
      n_cmp++;
      if (bus0.busy !== 1'b0 || bus5.busy !== 1'b0 || bus0.ram_cen !== 1'b1 || bus5.ram_cen !== 1'b1) begin
         n_err++; $display("FAIL reset_lat_builds: got busy %b/%b cen %b/%b required 0/0 1/1",
                           bus0.busy, bus5.busy, bus0.ram_cen, bus5.ram_cen);
      end
      reset_n = 1'b1;
      @(negedge mclk);
   endtask

   task automatic test_full_run();
      run_check("full_run", 4'($urandom), 1'b0);
   endtask

   task automatic test_scale();
      run_check("scale", 4'b1010, 1'b0);
   endtask

   task automatic test_start_ignored();
      run_check("start_ignored", 4'($urandom), 1'b1);
   endtask

   task automatic test_latency();
      int d0, d5;
      d0 = -1; d5 = -1;
      bus0.start = 1'b1; bus5.start = 1'b1;
      @(negedge mclk);
      bus0.start = 1'b0; bus5.start = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge mclk);
         if (bus0.done === 1'b1 && d0 < 0) d0 = c;
         if (bus5.done === 1'b1 && d5 < 0) d5 = c;
      end
      n_cmp++;
      if (d0 != 161) begin
         n_err++; $display("FAIL latency_lat0: got %0d required 161", d0);
      end
      n_cmp++;
      if (d5 != 321) begin
         n_err++; $display("FAIL latency_lat5: got %0d required 321", d5);
      end
   endtask

   task automatic test_back_to_back();
      sbus.scale_mask = 4'($urandom);
      sbus.start = 1'b1;
      @(negedge mclk);
      for (int c = 1; c <= 227; c++) begin
         @(negedge mclk);
         if (c == 225) begin
            n_cmp++;
            if (sbus.done !== 1'b1 || sbus.busy !== 1'b1) begin
               n_err++; $display("FAIL b2b_done: got done=%b busy=%b required 1 1", sbus.done, sbus.busy);
            end
         end
         if (c == 226) begin
            n_cmp++;
            if (sbus.busy !== 1'b0 || sbus.done !== 1'b0) begin
               n_err++; $display("FAIL b2b_idle: got busy=%b done=%b required 0 0", sbus.busy, sbus.done);
            end
         end
         if (c == 227) begin
            n_cmp++;
            if ({sbus.busy, sbus.ram_cen, sbus.ram_wen, sbus.ram_addr, sbus.stage} !==
                {1'b1, 1'b0, 2'b11, 4'd0, 4'd0}) begin
               n_err++; $display("FAIL b2b_restart: got busy=%b cen=%b wen=%b addr=%0d stage=%0d required 1 0 11 0 0",
                                 sbus.busy, sbus.ram_cen, sbus.ram_wen, sbus.ram_addr, sbus.stage);
            end
         end
      end
      sbus.start = 1'b0;
      reset_n = 1'b0;
      @(negedge mclk);
      reset_n = 1'b1;
      @(negedge mclk);
   endtask

   task automatic test_reset_midrun();
      bit found, quiet;
      found = 0; quiet = 1;
      sbus.scale_mask = 4'($urandom);
      sbus.start = 1'b1;
      @(negedge mclk);
      sbus.start = 1'b0;
      for (int c = 1; c <= 300 && !found; c++) begin
         @(negedge mclk);
         if (sbus.bfly_go === 1'b1 && sbus.stage === 4'd1) found = 1;
      end
      n_cmp++;
      if (!found) begin
         n_err++; $display("FAIL midrun_reach_stage1: got timeout required stage 1 capture");
      end
      reset_n = 1'b0;
      @(negedge mclk);
      reset_n = 1'b1;
      n_cmp++;
      if (out_vec() !== RST_V) begin
         n_err++; $display("FAIL midrun_reset_outputs: got %h required %h", out_vec(), RST_V);
      end
      for (int c = 0; c < 30; c++) begin
         @(negedge mclk);
         if (sbus.ram_cen !== 1'b1 || sbus.ram_wen !== 2'b11 || sbus.busy !== 1'b0) quiet = 0;
      end
      n_cmp++;
      if (!quiet) begin
         n_err++; $display("FAIL midrun_no_access: got RAM activity or busy after reset required none");
      end
   endtask

   initial begin
      sbus.start = 1'b0; sbus.scale_mask = '0;
      bus0.start = 1'b0; bus0.scale_mask = '0;
      bus5.start = 1'b0; bus5.scale_mask = '0;
      test_reset();
      test_full_run();
      test_scale();
      test_start_ignored();
      test_latency();
      test_back_to_back();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
